// File: rtl/mac_pkg.sv
// mac_pkg: instruction encoding shared by the skewed MAC array, its interface and its PEs.
package mac_pkg;
  typedef logic [1:0] inst_t;
  localparam inst_t INST_IDLE  = 2'b00;
  localparam inst_t INST_LOAD  = 2'b01;
  localparam inst_t INST_EXEC  = 2'b10;
  localparam inst_t INST_CLEAR = 2'b11;
endpackage

// File: rtl/mac_array_skewed_if.sv
// mac_array_skewed_if: aligned west/north inputs and south outputs of the skewed MAC array.
interface mac_array_skewed_if #(
  parameter int BW      = 4,
  parameter int PSUM_BW = 16,
  parameter int ROW     = 8,
  parameter int COL     = 8
);
  import mac_pkg::*;
  inst_t                  inst_w;
  logic [ROW*BW-1:0]      in_w;
  logic [COL*PSUM_BW-1:0] in_n;
  logic [COL*PSUM_BW-1:0] out_s;
  logic [COL-1:0]         valid;
  logic                   weights_loaded;
  modport master (output inst_w, in_w, in_n, input out_s, valid, weights_loaded);
  modport slave  (input inst_w, in_w, in_n, output out_s, valid, weights_loaded);
endinterface

// File: rtl/mac_pe.sv
// mac_pe: weight-stationary MAC tile; MAC_ARRAY_SAT_EN switches the psum add from wrap to saturate.
module mac_pe import mac_pkg::*; #(
  parameter int BW      = 4,
  parameter int PSUM_BW = 16,
  parameter bit SIGNED  = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  inst_t              inst_in,
  input  logic [BW-1:0]      a_in,
  input  logic [PSUM_BW-1:0] psum_in,
  output inst_t              inst_q,
  output logic [BW-1:0]      a_q,
  output logic [PSUM_BW-1:0] c_q,
  output logic               load_ready,
  output logic               valid_q
);
  logic [BW-1:0]          b_q;
  logic signed [2*BW-1:0] prod_s;
  logic [2*BW-1:0]        prod_u;
  logic [PSUM_BW-1:0]     prod_x, sum;
  logic                   take;
  assign prod_s = (2*BW)'($signed(a_in)) * (2*BW)'($signed(b_q));
  assign prod_u = (2*BW)'(a_in) * (2*BW)'(b_q);
  assign prod_x = SIGNED ? PSUM_BW'(prod_s) : PSUM_BW'(prod_u);
  assign take   = inst_in == INST_LOAD && load_ready;
`ifdef MAC_ARRAY_SAT_EN
  logic [PSUM_BW:0] wide;
  assign wide = SIGNED ? {psum_in[PSUM_BW-1], psum_in} + {prod_x[PSUM_BW-1], prod_x}
                       : {1'b0, psum_in} + {1'b0, prod_x};
  // signed overflow shows as a disagreement between the two top bits of the widened sum
  assign sum  = SIGNED ? ((wide[PSUM_BW] ^ wide[PSUM_BW-1]) ? {wide[PSUM_BW], {(PSUM_BW-1){~wide[PSUM_BW]}}} : wide[PSUM_BW-1:0])
                       : (wide[PSUM_BW] ? '1 : wide[PSUM_BW-1:0]);
`else
  assign sum = psum_in + prod_x;
`endif
  always_ff @(posedge clk)
    if (reset) begin
      inst_q     <= INST_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      load_ready <= 1'b1;
      valid_q    <= 1'b0;
    end else begin
      a_q     <= a_in;
      inst_q  <= take ? INST_IDLE : inst_in;
      valid_q <= inst_in == INST_EXEC;
      if (take) begin
        b_q        <= a_in;
        load_ready <= 1'b0;
      end
      if (inst_in == INST_EXEC) c_q <= sum;
      if (inst_in == INST_CLEAR) begin
        b_q        <= '0;
        load_ready <= 1'b1;
        c_q        <= '0;
      end
    end
endmodule

// File: rtl/mac_array_skewed.sv
// mac_array_skewed: ROW x COL weight-stationary systolic MAC grid with internal row skew.
// Optional MAC_ARRAY_SAT_EN (in mac_pe) saturates every psum add instead of wrapping.
module mac_array_skewed import mac_pkg::*; #(
  parameter int BW      = 4,
  parameter int PSUM_BW = 16,
  parameter int ROW     = 8,
  parameter int COL     = 8,
  parameter bit SIGNED  = 1'b1
) (
  input logic              clk,
  input logic              reset,
  mac_array_skewed_if.slave bus
);
  logic [PSUM_BW-1:0]   ps [0:ROW][0:COL-1];
  logic [COL-1:0]       vl [0:ROW-1];
  logic [ROW*COL-1:0]   rdy;
  assign bus.weights_loaded = ~|rdy;
  assign bus.valid          = vl[ROW-1];
  for (genvar c = 0; c < COL; c++) begin : g_col
    assign ps[0][c]                            = bus.in_n[c*PSUM_BW +: PSUM_BW];
    assign bus.out_s[c*PSUM_BW +: PSUM_BW]     = ps[ROW][c];
  end
  for (genvar r = 0; r < ROW; r++) begin : g_row
    inst_t         sk_i [0:r];
    logic [BW-1:0] sk_a [0:r];
    inst_t         ih   [0:COL];
    logic [BW-1:0] ah   [0:COL];
    // row r sees the vector r+1 cycles after issue, giving the diagonal wavefront
    always_ff @(posedge clk)
      if (reset) begin
        sk_i <= '{default: INST_IDLE};
        sk_a <= '{default: '0};
      end else begin
        sk_i[0] <= bus.inst_w;
        sk_a[0] <= bus.in_w[r*BW +: BW];
        for (int k = 1; k <= r; k++) begin
          sk_i[k] <= sk_i[k-1];
          sk_a[k] <= sk_a[k-1];
        end
      end
    assign ih[0] = sk_i[r];
    assign ah[0] = sk_a[r];
    for (genvar c = 0; c < COL; c++) begin : g_pe
      mac_pe #(.BW(BW), .PSUM_BW(PSUM_BW), .SIGNED(SIGNED)) u_pe (
        .clk        (clk),
        .reset      (reset),
        .inst_in    (ih[c]),
        .a_in       (ah[c]),
        .psum_in    (ps[r][c]),
        .inst_q     (ih[c+1]),
        .a_q        (ah[c+1]),
        .c_q        (ps[r+1][c]),
        .load_ready (rdy[r*COL+c]),
        .valid_q    (vl[r][c])
      );
    end
  end
endmodule

// File: tb/tb_mac_array_skewed.sv
// tb_mac_array_skewed: 2x2 signed array, 8-bit psums; table vectors, corner sequences and random EXEC traffic.
module tb_mac_array_skewed;
  import mac_pkg::*;
  localparam int BW = 4, P = 8, ROW = 2, COL = 2, N = 1024;
  localparam int PMAX = 2**(P-1) - 1, PMIN = -(2**(P-1));
`ifdef MAC_ARRAY_SAT_EN
  localparam int EXP6 = 127;
`else
  localparam int EXP6 = -107;
`endif
  logic clk = 1'b0, reset;
  always #5 clk = ~clk;
  mac_array_skewed_if #(.BW(BW), .PSUM_BW(P), .ROW(ROW), .COL(COL)) bus();
  mac_array_skewed #(.BW(BW), .PSUM_BW(P), .ROW(ROW), .COL(COL), .SIGNED(1'b1)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  typedef struct {int x0; int x1; int b0; int e0; int e1;} vec_t;
  vec_t tbl [6];
  int w [ROW][COL];
  int nload, cyc, tests, fails, e;
  bit ev [N][COL];
  int ed [N][COL];
  int bs [N][COL];
  function automatic int fit(int v);
`ifdef MAC_ARRAY_SAT_EN
    return v > PMAX ? PMAX : (v < PMIN ? PMIN : v);
`else
    logic signed [P-1:0] t;
    t = P'(v);
    return int'(t);
`endif
  endfunction
  function automatic int out_col(int c);
    logic signed [P-1:0] t;
    t = bus.out_s[c*P +: P];
    return int'(t);
  endfunction
  task automatic chk(string n, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", n, cyc, act, exp);
    end
  endtask
  // drive one vector, update the reference model, then compare against the scoreboard
  task automatic tick(logic [1:0] inst, int x0 = 0, int x1 = 0, int b0 = 0, int b1 = 0);
    int x [ROW];
    int b [COL];
    int acc, ne;
    ne = cyc + 1;
    x[0] = x0; x[1] = x1; b[0] = b0; b[1] = b1;
    bus.inst_w = inst;
    bus.in_w   = {x1[BW-1:0], x0[BW-1:0]};
    bus.in_n   = {bs[ne][1][P-1:0], bs[ne][0][P-1:0]};
    if (reset) begin
      nload = 0;
      w = '{default: 0};
      for (int i = ne; i < N; i++)
        for (int c = 0; c < COL; c++) begin
          ev[i][c] = 1'b0;
          bs[i][c] = 0;
        end
    end else if (inst == INST_CLEAR) begin
      nload = 0;
      w = '{default: 0};
    end else if (inst == INST_LOAD) begin
      if (nload < COL) begin
        for (int r = 0; r < ROW; r++) w[r][nload] = x[r];
        nload++;
      end
    end else if (inst == INST_EXEC) begin
      for (int c = 0; c < COL; c++) begin
        acc = fit(b[c]);
        for (int r = 0; r < ROW; r++) acc = fit(acc + x[r] * w[r][c]);
        ev[ne+ROW+c][c] = 1'b1;
        ed[ne+ROW+c][c] = acc;
        bs[ne+1+c][c]   = b[c];
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    for (int c = 0; c < COL; c++) begin
      chk($sformatf("valid[%0d]", c), int'(bus.valid[c]), int'(ev[cyc][c]));
      if (ev[cyc][c]) chk($sformatf("out_s[%0d]", c), out_col(c), ed[cyc][c]);
    end
  endtask
  task automatic run_vec(int i);
    int t0;
    tick(INST_EXEC, tbl[i].x0, tbl[i].x1, tbl[i].b0, 0);
    t0 = cyc;
    while (cyc < t0 + ROW) tick(INST_IDLE);
    chk($sformatf("vec%0d col0", i), out_col(0), tbl[i].e0);
    chk($sformatf("vec%0d valid0", i), int'(bus.valid[0]), 1);
    tick(INST_IDLE);
    chk($sformatf("vec%0d col1", i), out_col(1), tbl[i].e1);
    chk($sformatf("vec%0d valid1", i), int'(bus.valid[1]), 1);
    chk($sformatf("vec%0d valid0 pulse", i), int'(bus.valid[0]), 0);
    tick(INST_IDLE);
  endtask
  initial begin
    tbl = '{'{5, -2, 0, -1, 18}, '{5, -2, 100, 99, 18}, '{1, 0, 0, 1, 2},
            '{-8, 7, 0, 13, -44}, '{7, 7, 0, 28, -14}, '{0, 0, -50, -50, 0}};
    cyc = 0; tests = 0; fails = 0; nload = 0;
    w = '{default: 0};
    reset = 1'b1;
    bus.inst_w = INST_IDLE; bus.in_w = '0; bus.in_n = '0;
    repeat (3) tick(INST_IDLE);
    chk("reset out_s", int'(bus.out_s), 0);
    chk("reset valid", int'(bus.valid), 0);
    chk("reset weights_loaded", int'(bus.weights_loaded), 0);
    reset = 1'b0;
    repeat (10) tick(INST_IDLE);
    chk("idle out_s", int'(bus.out_s), 0);
    chk("idle weights_loaded", int'(bus.weights_loaded), 0);
    tick(INST_LOAD, 1, 3);
    tick(INST_LOAD, 2, -4);
    e = cyc;
    repeat (5) begin
      tick(INST_IDLE);
      chk("load weights_loaded", int'(bus.weights_loaded), int'(cyc >= e + ROW + COL - 1));
    end
    for (int i = 0; i < 6; i++) run_vec(i);
    for (int k = 0; k < ROW + 6; k++) begin
      if (k < 4) tick(INST_EXEC, k + 1, 0); else tick(INST_IDLE);
      if (k == 0) e = cyc;
      if (cyc >= e + ROW && cyc < e + ROW + 4) chk("stream col0", out_col(0), cyc - e - ROW + 1);
    end
    tick(INST_CLEAR);
    tick(INST_EXEC, 5, -2);
    repeat (ROW + COL + 1) tick(INST_IDLE);
    chk("clear weights_loaded", int'(bus.weights_loaded), 0);
    chk("clear col0", out_col(0), 0);
    chk("clear col1", out_col(1), 0);
    tick(INST_LOAD, 1, 3);
    tick(INST_LOAD, 2, -4);
    repeat (ROW + COL) tick(INST_IDLE);
    chk("reload weights_loaded", int'(bus.weights_loaded), 1);
    run_vec(0);
    tick(INST_CLEAR);
    tick(INST_LOAD, int'($urandom_range(15)) - 8, int'($urandom_range(15)) - 8);
    tick(INST_LOAD, int'($urandom_range(15)) - 8, int'($urandom_range(15)) - 8);
    repeat (ROW + COL) tick(INST_IDLE);
    repeat (80)
      tick($urandom_range(2) != 0 ? INST_EXEC : INST_IDLE,
           int'($urandom_range(15)) - 8, int'($urandom_range(15)) - 8,
           int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128);
    repeat (ROW + COL + 2) tick(INST_IDLE);
    tick(INST_CLEAR);
    tick(INST_LOAD, 7, 7);
    tick(INST_LOAD, 7, 7);
    repeat (ROW + COL) tick(INST_IDLE);
    tick(INST_EXEC, 7, 0, 100, 100);
    e = cyc;
    while (cyc < e + ROW) tick(INST_IDLE);
    chk("overflow col0", out_col(0), EXP6);
    repeat (3) tick(INST_EXEC, 7, 7, 100, 100);
    reset = 1'b1;
    tick(INST_EXEC, 7, 7, 100, 100);
    chk("midreset valid", int'(bus.valid), 0);
    chk("midreset weights_loaded", int'(bus.weights_loaded), 0);
    reset = 1'b0;
    repeat (4) tick(INST_IDLE);
    chk("post reset out_s", int'(bus.out_s), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
